// File: rtl/clock_time_set.sv
// -----------------------------------------------------------------------------
// clock_time_set
//
// Time-of-day counter and time-set controller for the HDL clock. Keeps a
// 24-hour BCD time that advances on the 1 Hz enable while running, and lets
// the user step through hour/minute/second set fields with the mode key and
// bump the selected field with the increment key.
//
// Parameters:
//   GAP       pulse-free clk cycles on mode_p needed before another mode_p
//             is accepted (lockout against the button stage auto-repeat)
//
// Ports:
//   clk       system clock
//   clr       asynchronous active-high reset
//   tick_1hz  one-cycle enable, once per second
//   mode_p    mode key pulse (repeats while held)
//   inc_p     increment key pulse (repeats while held)
//   hour_bcd  hours, BCD 00-23
//   min_bcd   minutes, BCD 00-59
//   sec_bcd   seconds, BCD 00-59
//   sel       one-hot field being set: [2]=hour [1]=min [0]=sec, 000 in RUN
//   day_p     one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//
// Handshake: there are no valid/ready pairs; every input is a single-cycle
// strobe sampled on the rising clk edge, and every output is registered so
// an event sampled at edge N is visible right after edge N.
//
// The controller state is fully visible on sel (one-hot set field, or 000
// for RUN), which doubles as the state debug view.
// -----------------------------------------------------------------------------
module clock_time_set #(
    parameter int GAP = 150000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_1hz,
    input  logic       mode_p,
    input  logic       inc_p,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [2:0] sel,
    output logic       day_p
);

    localparam int              GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_MAX = GW'(GAP - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            lock_q, lock_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      hour_q, hour_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      sec_q, sec_d;
    logic [2:0]      sel_q, sel_d;
    logic            day_q, day_d;
    logic            accept;

    // Per-digit BCD increment that wraps to 00 once the value equals top.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        gap_d   = gap_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = 1'b0;
        sel_d   = 3'b000;

        accept = mode_p && !lock_q;

        // Mode lockout: any mode pulse restarts the quiet-period count. The
        // lock drops on the GAP-th consecutive quiet cycle, i.e. the quiet
        // cycle that finds the counter already saturated at GAP-1.
        if (mode_p) begin
            gap_d = '0;
            if (!lock_q)
                lock_d = 1'b1;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end else begin
            lock_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end

        // Time updates are decided by the state before the edge, so a tick
        // on RUN->SET_H still counts and a tick on SET_S->RUN is dropped.
        unique case (state_q)
            RUN: begin
                if (tick_1hz) begin
                    sec_d = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59) begin
                            hour_d = bcd_inc(hour_q, 8'h23);
                            if (hour_q == 8'h23)
                                day_d = 1'b1;
                        end
                    end
                end
            end
            SET_H: if (inc_p && !accept) hour_d = bcd_inc(hour_q, 8'h23);
            SET_M: if (inc_p && !accept) min_d  = bcd_inc(min_q, 8'h59);
            default: if (inc_p && !accept) sec_d = bcd_inc(sec_q, 8'h59);
        endcase

        unique case (state_d)
            SET_H:   sel_d = 3'b100;
            SET_M:   sel_d = 3'b010;
            SET_S:   sel_d = 3'b001;
            default: sel_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= RUN;
            lock_q  <= 1'b0;
            gap_q   <= '0;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            sel_q   <= 3'b000;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            gap_q   <= gap_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            sel_q   <= sel_d;
            day_q   <= day_d;
        end
    end

    assign hour_bcd = hour_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign sel      = sel_q;
    assign day_p    = day_q;

endmodule

// File: tb/tb_clock_time_set.sv
// -----------------------------------------------------------------------------
// tb_clock_time_set
//
// Directed bench for clock_time_set with GAP=8. Inputs are driven on the
// falling edge and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_time_set;

    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       mode_p = 1'b0;
    logic       inc_p = 1'b0;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [2:0] sel;
    logic       day_p;

    int checks = 0;
    int failures = 0;

    clock_time_set #(.GAP(GAP)) dut (
        .clk      (clk),
        .clr      (clr),
        .tick_1hz (tick_1hz),
        .mode_p   (mode_p),
        .inc_p    (inc_p),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .sel      (sel),
        .day_p    (day_p)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; tick_1hz = 1'b0; mode_p = 1'b0; inc_p = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // ---------------- drivers ----------------
    // One clock cycle with the given strobes; returns just after the edge.
    task automatic drive(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick_1hz = t; mode_p = m; inc_p = i;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; mode_p = 1'b0; inc_p = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        repeat (h) drive(1'b0, 1'b0, 1'b1);
        idle(GAP + 2);
        drive(1'b0, 1'b1, 1'b0);
        repeat (m) drive(1'b0, 1'b0, 1'b1);
        idle(GAP + 2);
        drive(1'b0, 1'b1, 1'b0);
        repeat (s) drive(1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin failures++; $display("FAIL reset_time got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
        checks++; if (sel !== 3'b000) begin failures++; $display("FAIL reset_sel got=%b exp=000", sel); end
        checks++; if (day_p !== 1'b0) begin failures++; $display("FAIL reset_day got=%b exp=0", day_p); end
    endtask

    task automatic test_day_rollover();
        int bad;
        int first_bad;
        do_reset();
        bad = 0;
        first_bad = -1;
        @(negedge clk);
        tick_1hz = 1'b1;
        for (int k = 1; k <= 86399; k++) begin
            @(negedge clk);
            if (hour_bcd !== to_bcd(k / 3600) || min_bcd !== to_bcd((k / 60) % 60) ||
                sec_bcd !== to_bcd(k % 60) || sel !== 3'b000 || day_p !== 1'b0) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL day_sweep bad_ticks=%0d first_bad_tick=%0d exp_bad=0", bad, first_bad); end
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin failures++; $display("FAIL day_235959 got=%h exp=235959", {hour_bcd, min_bcd, sec_bcd}); end
        // tick is still high: the next edge is tick 86400
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin failures++; $display("FAIL day_wrap got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
        checks++; if (day_p !== 1'b1) begin failures++; $display("FAIL day_pulse_hi got=%b exp=1", day_p); end
        checks++; if (sel !== 3'b000) begin failures++; $display("FAIL day_sel got=%b exp=000", sel); end
        @(negedge clk);
        checks++; if (day_p !== 1'b0) begin failures++; $display("FAIL day_pulse_lo got=%b exp=0", day_p); end
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0);
            idle(2);
        end
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000003 || day_p !== 1'b0) begin failures++; $display("FAIL spaced_ticks got=%h day=%b exp=000003 day=0", {hour_bcd, min_bcd, sec_bcd}, day_p); end
    endtask

    task automatic test_mode_lockout();
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (sel !== 3'b100) begin failures++; $display("FAIL lock_first got=%b exp=100", sel); end
        repeat (7) begin
            idle(4);
            drive(1'b0, 1'b1, 1'b0);
        end
        idle(4);
        checks++; if (sel !== 3'b100) begin failures++; $display("FAIL lock_held got=%b exp=100", sel); end
        idle(6);
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (sel !== 3'b010) begin failures++; $display("FAIL lock_release got=%b exp=010", sel); end
    endtask

    task automatic test_set_hour();
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        repeat (9) drive(1'b0, 1'b0, 1'b1);
        checks++; if (hour_bcd !== 8'h09) begin failures++; $display("FAIL hour_09 got=%h exp=09", hour_bcd); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (hour_bcd !== 8'h10) begin failures++; $display("FAIL hour_10 got=%h exp=10", hour_bcd); end
        repeat (12) drive(1'b0, 1'b0, 1'b1);
        checks++; if (hour_bcd !== 8'h22) begin failures++; $display("FAIL hour_22 got=%h exp=22", hour_bcd); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (hour_bcd !== 8'h23) begin failures++; $display("FAIL hour_23 got=%h exp=23", hour_bcd); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h230000) begin failures++; $display("FAIL hour_frozen got=%h exp=230000", {hour_bcd, min_bcd, sec_bcd}); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (hour_bcd !== 8'h00) begin failures++; $display("FAIL hour_wrap got=%h exp=00", hour_bcd); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h010000) begin failures++; $display("FAIL hour_01 got=%h exp=010000", {hour_bcd, min_bcd, sec_bcd}); end
        checks++; if (sel !== 3'b100) begin failures++; $display("FAIL hour_sel got=%b exp=100", sel); end
    endtask

    // Continues from SET_H at 01:00:00.
    task automatic test_set_min_sec();
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (sel !== 3'b010) begin failures++; $display("FAIL min_sel got=%b exp=010", sel); end
        repeat (59) drive(1'b0, 1'b0, 1'b1);
        checks++; if (min_bcd !== 8'h59) begin failures++; $display("FAIL min_59 got=%h exp=59", min_bcd); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if ({hour_bcd, min_bcd} !== 16'h0100) begin failures++; $display("FAIL min_wrap got=%h exp=0100", {hour_bcd, min_bcd}); end
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (sel !== 3'b001) begin failures++; $display("FAIL sec_sel got=%b exp=001", sel); end
        repeat (9) drive(1'b0, 1'b0, 1'b1);
        checks++; if (sec_bcd !== 8'h09) begin failures++; $display("FAIL sec_09 got=%h exp=09", sec_bcd); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h010010) begin failures++; $display("FAIL sec_10 got=%h exp=010010", {hour_bcd, min_bcd, sec_bcd}); end
    endtask

    task automatic test_simultaneous();
        set_time(12, 34, 56);
        checks++; if ({sel, hour_bcd, min_bcd, sec_bcd} !== {3'b001, 24'h123456}) begin failures++; $display("FAIL sim_setup got=%b/%h exp=001/123456", sel, {hour_bcd, min_bcd, sec_bcd}); end
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (sel !== 3'b000) begin failures++; $display("FAIL sim_sel got=%b exp=000", sel); end
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123456) begin failures++; $display("FAIL sim_time got=%h exp=123456", {hour_bcd, min_bcd, sec_bcd}); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123457) begin failures++; $display("FAIL sim_tick got=%h exp=123457", {hour_bcd, min_bcd, sec_bcd}); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (sec_bcd !== 8'h57) begin failures++; $display("FAIL run_inc_ignored got=%h exp=57", sec_bcd); end
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (sec_bcd !== 8'h58) begin failures++; $display("FAIL run_tick_inc got=%h exp=58", sec_bcd); end
        idle(GAP + 2);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if ({sel, sec_bcd} !== {3'b100, 8'h59}) begin failures++; $display("FAIL run_to_seth_tick got=%b/%h exp=100/59", sel, sec_bcd); end
        idle(GAP + 2);
        drive(1'b0, 1'b1, 1'b1);
        checks++; if ({sel, hour_bcd} !== {3'b010, 8'h12}) begin failures++; $display("FAIL mode_inc_discard got=%b/%h exp=010/12", sel, hour_bcd); end
    endtask

    task automatic test_clr_mid_lockout();
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b1);
        idle(GAP + 2);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (i % 4 == 3) drive(1'b0, 1'b1, 1'b0);
        end
        checks++; if ({sel, hour_bcd, min_bcd} !== {3'b010, 16'h0517}) begin failures++; $display("FAIL clr_setup got=%b/%h exp=010/0517", sel, {hour_bcd, min_bcd}); end
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++; if ({sel, day_p, hour_bcd, min_bcd, sec_bcd} !== {3'b000, 1'b0, 24'h000000}) begin failures++; $display("FAIL clr_async got=%b/%b/%h exp=000/0/000000", sel, day_p, {hour_bcd, min_bcd, sec_bcd}); end
        @(negedge clk);
        clr = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        checks++; if ({sel, hour_bcd} !== {3'b100, 8'h00}) begin failures++; $display("FAIL clr_mode_after got=%b/%h exp=100/00", sel, hour_bcd); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_day_rollover();
        test_mode_lockout();
        test_set_hour();
        test_set_min_sec();
        test_simultaneous();
        test_clr_mid_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
